uart_tx_fifo: RTL

- Serial transmitter counterpart to the 9600-baud UART receive path that feeds PET keystrokes.
- Accepts bytes over a write-strobe handshake, buffers them in a FIFO, and sends 8N1 frames LSB-first on serial_out.
- Used at the board top to send PET-originated characters (screen/echo traffic) back to the host over the USB/UART bridge, so the host is not limited to a raw loopback of UART_TXD_IN.

---
 rtl/uart_tx_fifo.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Byte FIFO feeding an 8N1 LSB-first UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_DIVIDER = 5208,
    parameter int FIFO_AW     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         write_data,
    input  logic               write_strobe,
    output logic               write_rdy,
    output logic               serial_out,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);

    localparam int                 c_DEPTH     = 1 << FIFO_AW;
    localparam int                 c_BCW       = $clog2(CLK_DIVIDER);
    localparam logic [c_BCW-1:0]   c_BAUD_LAST = c_BCW'(CLK_DIVIDER - 1);
    localparam logic [FIFO_AW:0]   c_FULL      = (FIFO_AW + 1)'(c_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]         r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic [FIFO_AW:0]   w_count_next;
    logic               r_write_rdy;
    logic               r_overflow;
    logic               r_serial;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_BCW-1:0]   r_bcnt;
    logic [c_BCW-1:0]   w_bcnt_next;
    logic [2:0]         r_bidx;
    logic [2:0]         w_bidx_next;
    logic [7:0]         r_shreg;
    logic [7:0]         w_shreg_next;
    logic               w_serial_next;

    logic               w_push;
    logic               w_pop;
    logic               w_bit_end;
    logic               w_fifo_nonempty;

    assign w_push          = write_strobe & r_write_rdy;
    assign w_fifo_nonempty = (r_count != '0);
    assign w_bit_end       = (r_bcnt == c_BAUD_LAST);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Storage is left unreset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_write_rdy <= 1'b1;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count     <= w_count_next;
            r_write_rdy <= (w_count_next != c_FULL);
            // A strobe while full is lost even if a pop frees a slot this cycle.
            if (write_strobe && !r_write_rdy) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_bcnt   <= '0;
            r_bidx   <= '0;
            r_shreg  <= '0;
            r_serial <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            r_bcnt   <= w_bcnt_next;
            r_bidx   <= w_bidx_next;
            r_shreg  <= w_shreg_next;
            r_serial <= w_serial_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_bcnt_next  = w_bit_end ? '0 : r_bcnt + 1'b1;
        w_bidx_next  = r_bidx;
        w_shreg_next = r_shreg;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_bcnt_next = '0;
                if (w_fifo_nonempty) begin
                    w_pop        = 1'b1;
                    w_shreg_next = r_mem[r_rptr];
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_bidx_next  = '0;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shreg_next = {1'b0, r_shreg[7:1]};
                    w_bidx_next  = r_bidx + 1'b1;
                    if (r_bidx == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (w_fifo_nonempty) begin
                        w_pop        = 1'b1;
                        w_shreg_next = r_mem[r_rptr];
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
        endcase
    end

    // Line level is derived from the next state so the output register tracks the FSM exactly.
    always_comb begin
        w_serial_next = 1'b1;
        if (w_state_next == S_START) begin
            w_serial_next = 1'b0;
        end else if (w_state_next == S_DATA) begin
            w_serial_next = w_shreg_next[0];
        end
    end

    assign write_rdy  = r_write_rdy;
    assign serial_out = r_serial;
    assign busy       = (r_state != S_IDLE) | w_fifo_nonempty;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire
